tdm_demux: RTL and testbench

- Receive end of a time-division multiplexed serial link; the counterpart of the team's mux blocks.
- A single serial bit stream carries CH channels, each a W-bit slot, sent MSB-first and marked by a frame-sync pulse.
- The block locks to frame sync, deserialises each slot, and routes the word to that channel's output register with a one-cycle valid strobe.
- It sits between the serial line interface and the per-channel consumer logic.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 50 +++++
 rtl/tdm_demux.sv | 135 +++++++++++++
 tb/tb_tdm_demux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM receive path: FSM encoding and default frame geometry.
package tdm_pkg;

  typedef logic [0:0] tdm_state_t;

  localparam tdm_state_t StHunt   = 1'b0;
  localparam tdm_state_t StLocked = 1'b1;

  localparam int unsigned DefaultCh = 4;
  localparam int unsigned DefaultW  = 8;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-within-slot and slot-within-frame position counters for the TDM receiver.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned  CH = DefaultCh,
  parameter int unsigned  W  = DefaultW,
  localparam int unsigned SW = $clog2(CH),
  localparam int unsigned BW = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_load_first,
  input  logic          i_advance,
  output logic [BW-1:0] o_bitcnt,
  output logic [SW-1:0] o_slot,
  output logic          o_slot_last,
  output logic          o_frame_boundary
);

  localparam logic [BW-1:0] LastBit  = BW'(W - 1);
  localparam logic [SW-1:0] LastSlot = SW'(CH - 1);

  logic [BW-1:0] r_bitcnt;
  logic [SW-1:0] r_slot;

  // load_first marks the cycle that carried bit 0 of slot 0, so the next bit is bit 1.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_bitcnt <= '0;
      r_slot   <= '0;
    end else if (i_load_first) begin
      r_bitcnt <= BW'(1);
      r_slot   <= '0;
    end else if (i_advance) begin
      if (r_bitcnt == LastBit) begin
        r_bitcnt <= '0;
        r_slot   <= (r_slot == LastSlot) ? '0 : r_slot + SW'(1);
      end else begin
        r_bitcnt <= r_bitcnt + BW'(1);
      end
    end
  end

  assign o_bitcnt         = r_bitcnt;
  assign o_slot           = r_slot;
  assign o_slot_last      = (r_bitcnt == LastBit);
  assign o_frame_boundary = (r_slot == '0) && (r_bitcnt == '0);

endmodule

// File: rtl/tdm_demux.sv
// TDM serial receiver: locks to frame sync, deserialises MSB-first slots and
// routes each completed word to its channel register with a one-cycle valid strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned  CH = DefaultCh,
  parameter int unsigned  W  = DefaultW,
  localparam int unsigned SW = $clog2(CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_din,
  input  logic            i_fs,
  output logic [CH*W-1:0] o_out_data,
  output logic [CH-1:0]   o_out_valid,
  output logic [SW-1:0]   o_sel,
  output logic            o_locked,
  output logic            o_sync_err
);

  localparam int unsigned BW  = $clog2(W);
  localparam int unsigned SRW = W - 1;

  tdm_state_t      r_state;
  logic [SRW-1:0]  r_shift;
  logic [CH*W-1:0] r_data;
  logic [CH-1:0]   r_valid;

  tdm_state_t      w_state_nxt;
  logic            w_clear;
  logic            w_load_first;
  logic            w_advance;
  logic            w_fault;
  logic            w_word_done;
  logic [W-1:0]    w_word;
  logic [CH-1:0]   w_valid_nxt;
  logic [BW-1:0]   w_bitcnt;
  logic [SW-1:0]   w_slot;
  logic            w_slot_last;
  logic            w_boundary;
  logic            w_unused_bitcnt;

  tdm_slot_counter #(
    .CH (CH),
    .W  (W)
  ) u_slot_counter (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_clear          (w_clear),
    .i_load_first     (w_load_first),
    .i_advance        (w_advance),
    .o_bitcnt         (w_bitcnt),
    .o_slot           (w_slot),
    .o_slot_last      (w_slot_last),
    .o_frame_boundary (w_boundary)
  );

  assign w_unused_bitcnt = ^w_bitcnt;
  assign w_word          = {r_shift, i_din};

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_load_first = 1'b0;
    w_advance    = 1'b0;
    w_fault      = 1'b0;
    w_word_done  = 1'b0;
    unique case (r_state)
      StHunt: begin
        if (i_fs) begin
          w_load_first = 1'b1;
          w_state_nxt  = StLocked;
        end
      end
      StLocked: begin
        if (w_boundary && !i_fs) begin
          // Sync missing where expected: drop lock, discard this bit.
          w_fault     = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = StHunt;
        end else if (!w_boundary && i_fs) begin
          // Misplaced sync (including on a slot's last bit): restart the frame here.
          w_fault      = 1'b1;
          w_load_first = 1'b1;
        end else begin
          w_advance   = 1'b1;
          w_word_done = w_slot_last;
        end
      end
      default: begin
        w_state_nxt = StHunt;
        w_clear     = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_valid_nxt = '0;
    for (int k = 0; k < int'(CH); k++) begin
      w_valid_nxt[k] = w_word_done && (w_slot == SW'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StHunt;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (w_load_first) begin
        r_shift <= SRW'(i_din);
      end else if (w_advance) begin
        r_shift <= w_word[SRW-1:0];
      end else if (w_clear) begin
        r_shift <= '0;
      end
      for (int k = 0; k < int'(CH); k++) begin
        if (w_valid_nxt[k]) begin
          r_data[k*W +: W] <= w_word;
        end
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_sel       = w_slot;
  assign o_locked    = (r_state == StLocked);
  // Flags the offending cycle itself, so it is only ever seen while still locked.
  assign o_sync_err  = w_fault & ~i_rst;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: frame-position model compared every cycle,
// directed frames with literal expectations, then randomized sync/reset traffic.
module tb_tdm_demux;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = $clog2(CH);
  localparam int unsigned FL = CH * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            din = 1'b0;
  logic            fs  = 1'b0;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid;
  logic [SW-1:0]   sel;
  logic            locked;
  logic            sync_err;

  tdm_demux #(
    .CH (CH),
    .W  (W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_din       (din),
    .i_fs        (fs),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_sel       (sel),
    .o_locked    (locked),
    .o_sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  // Model: lock flag, bit position inside the frame, running bit accumulator.
  bit            m_ready  = 1'b0;
  bit            m_locked = 1'b0;
  int            m_pos    = 0;
  logic [31:0]   m_acc    = '0;
  logic [W-1:0]  m_data [CH];
  logic [CH-1:0] m_valid  = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_ready  = 1'b1;
      m_locked = 1'b0;
      m_pos    = 0;
      m_acc    = '0;
      m_valid  = '0;
      for (int k = 0; k < int'(CH); k++) m_data[k] = '0;
    end else if (m_ready) begin
      m_valid = '0;
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1;
          m_pos    = 1;
          m_acc    = {31'b0, din};
        end
      end else if (fs != (m_pos == 0)) begin
        if (fs) begin
          m_pos = 1;
          m_acc = {31'b0, din};
        end else begin
          m_locked = 1'b0;
          m_pos    = 0;
        end
      end else begin
        m_acc = {m_acc[30:0], din};
        if (m_pos % int'(W) == int'(W) - 1) begin
          m_data[m_pos / int'(W)]  = m_acc[W-1:0];
          m_valid[m_pos / int'(W)] = 1'b1;
        end
        m_pos = (m_pos + 1) % int'(FL);
      end
    end
  endtask

  task automatic compare();
    logic [CH*W-1:0] exp_data;
    logic            exp_err;
    for (int k = 0; k < int'(CH); k++) exp_data[k*W +: W] = m_data[k];
    exp_err = !rst && m_locked && (fs != (m_pos == 0));
    chk("data", 64'(out_data), 64'(exp_data));
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("sel", 64'(sel), 64'(m_pos / int'(W)));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("sync_err", 64'(sync_err), 64'(exp_err));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (sync_err === 1'b1) err_seen++;
    if (m_ready) compare();
  end

  // Apply one bit for one clock; returns 2 time units after the sampling edge.
  task automatic cyc(input logic r, input logic f, input logic d);
    rst = r;
    fs  = f;
    din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic with_fs);
    for (int i = int'(W) - 1; i >= 0; i--) cyc(1'b0, with_fs && (i == int'(W) - 1), w[i]);
  endtask

  logic [7:0] fa [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic [7:0] fb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] fc [4] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
  logic [7:0] fd [4] = '{8'h88, 8'h99, 8'hAA, 8'hBB};

  initial begin
    int e0;
    int gpos;
    logic r, f, d;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    chk("rst_sync_err", 64'(sync_err), 64'h0);

    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("hunt_locked", 64'(locked), 64'h0);

    // Clean lock, then a back-to-back second frame.
    e0 = err_seen;
    for (int k = 0; k < 4; k++) begin
      send_word(fa[k], k == 0);
      chk($sformatf("a_valid%0d", k), 64'(out_valid), 64'(1 << k));
    end
    chk("a_data", 64'(out_data), 64'h01FF3CA5);
    chk("a_locked", 64'(locked), 64'h1);
    for (int k = 0; k < 4; k++) begin
      send_word(fb[k], k == 0);
      chk($sformatf("b_valid%0d", k), 64'(out_valid), 64'(1 << k));
    end
    chk("b_data", 64'(out_data), 64'h44332211);
    chk("b_locked", 64'(locked), 64'h1);
    chk("ab_no_err", 64'(err_seen - e0), 64'h0);

    // Missing sync at the frame boundary, then relock.
    e0 = err_seen;
    cyc(1'b0, 1'b0, 1'b1);
    chk("miss_locked", 64'(locked), 64'h0);
    chk("miss_sel", 64'(sel), 64'h0);
    chk("miss_err", 64'(err_seen - e0), 64'h1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send_word(fc[k], k == 0);
    chk("relock_data", 64'(out_data), 64'hF00FC35A);
    chk("relock_locked", 64'(locked), 64'h1);

    // Early sync at bit 3 of slot 1.
    send_word(8'h77, 1'b1);
    e0 = err_seen;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    send_word(fd[0], 1'b1);
    chk("early_err", 64'(err_seen - e0), 64'h1);
    chk("early_valid", 64'(out_valid), 64'h1);
    chk("early_slice1", 64'(out_data[15:8]), 64'hC3);
    chk("early_slice0", 64'(out_data[7:0]), 64'h88);
    for (int k = 1; k < 4; k++) send_word(fd[k], 1'b0);
    chk("early_data", 64'(out_data), 64'hBBAA9988);

    // Sync on the last bit of slot 1: no word, realign to slot 0.
    send_word(8'h66, 1'b1);
    e0 = err_seen;
    for (int i = 7; i >= 1; i--) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("last_valid", 64'(out_valid), 64'h0);
    chk("last_err", 64'(err_seen - e0), 64'h1);
    for (int i = 6; i >= 0; i--) cyc(1'b0, 1'b0, 8'hC9 >> i);
    chk("last_valid0", 64'(out_valid), 64'h1);
    chk("last_slice0", 64'(out_data[7:0]), 64'hC9);
    chk("last_slice1", 64'(out_data[15:8]), 64'h99);

    // Reset at bit 5 of slot 2.
    send_word(8'h12, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'h2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("mid_rst_data", 64'(out_data), 64'h0);
    chk("mid_rst_locked", 64'(locked), 64'h0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'($urandom_range(1)));
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    send_word(8'hE7, 1'b1);
    chk("post_rst_word", 64'(out_data), 64'h000000E7);
    chk("post_rst_valid0", 64'(out_valid), 64'h1);

    // Random traffic: mostly on-schedule sync with occasional faults and resets.
    gpos = int'(W);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(299) == 0);
      f = (gpos == 0);
      if ($urandom_range(39) == 0) f = ~f;
      d = 1'($urandom_range(1));
      cyc(r, f, d);
      if (r) gpos = 0;
      else if (f) gpos = 1;
      else gpos = (gpos + 1) % int'(FL);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
